// File: rtl/nibble_serial_add_ctrl.sv
// Serial WIDTH-bit add/subtract sequencer driving one shared external 4-bit adder slice,
// one nibble per clock, LSB nibble first, with carry-out and signed overflow reporting.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_s,
  input  logic             add_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  // Adder slice inputs are live only during RUN so the shared slice sees zeros otherwise.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = op_a[4*idx +: 4];
      add_b   = op_b[4*idx +: 4];
      add_cin = carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_a   <= a;
            op_b   <= sub ? ~b : b;
            carry  <= cin ^ sub;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          result[4*idx +: 4] <= add_s;
          carry              <= add_cout;
          if (idx == LAST) begin
            // Final nibble: sign bits of the operands against the top sum bit give overflow.
            cout  <= add_cout;
            ovf   <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_s[3] != op_a[WIDTH-1]);
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl: 16-bit and 8-bit instances, each wired to
// a behavioural 4-bit adder slice.
module tb_nibble_serial_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        sub;
  logic        cin;
  logic        start16;
  logic [15:0] a16, b16;
  logic [3:0]  add_a16, add_b16, add_s16;
  logic        add_cin16, add_cout16;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] result16;
  logic        start8;
  logic [7:0]  a8, b8;
  logic [3:0]  add_a8, add_b8, add_s8;
  logic        add_cin8, add_cout8;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  result8;

  int unsigned checks;
  int unsigned errors;
  logic [3:0]  nib_seq [4];

  nibble_serial_add_ctrl #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub), .cin(cin), .a(a16), .b(b16),
    .add_a(add_a16), .add_b(add_b16), .add_cin(add_cin16), .add_s(add_s16), .add_cout(add_cout16),
    .busy(busy16), .done(done16), .result(result16), .cout(cout16), .ovf(ovf16)
  );

  nibble_serial_add_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub), .cin(cin), .a(a8), .b(b8),
    .add_a(add_a8), .add_b(add_b8), .add_cin(add_cin8), .add_s(add_s8), .add_cout(add_cout8),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8), .ovf(ovf8)
  );

  // External adder slices
  always_comb begin
    {add_cout16, add_s16} = 5'(add_a16) + 5'(add_b16) + 5'(add_cin16);
    {add_cout8,  add_s8}  = 5'(add_a8)  + 5'(add_b8)  + 5'(add_cin8);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle (lat = cycles after E0).
  task automatic run16(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                       input logic tc, input int inj, output int lat);
    a16 = ta; b16 = tb; sub = ts; cin = tc; start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    lat = 99;
    for (int n = 1; n <= 12; n++) begin
      if (n > 1) @(negedge clk);
      if (n <= 4) nib_seq[n-1] = add_a16;
      if (n == inj) begin
        start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; sub = ~ts; cin = ~tc;
      end else begin
        start16 = 1'b0;
      end
      if (done16) begin
        lat = n;
        break;
      end
    end
    start16 = 1'b0;
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                      input logic tc, output int lat);
    a8 = ta; b8 = tb; sub = ts; cin = tc; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    lat = 99;
    for (int n = 1; n <= 12; n++) begin
      if (n > 1) @(negedge clk);
      if (done8) begin
        lat = n;
        break;
      end
    end
  endtask

  int lat;

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; start16 = 1'b0; start8 = 1'b0; sub = 1'b0; cin = 1'b0;
    a16 = '0; b16 = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",   32'(busy16),   0);
    check("rst_done",   32'(done16),   0);
    check("rst_result", 32'(result16), 0);
    check("rst_cout_ovf", 32'({cout16, ovf16}), 0);
    check("rst_add_a",  32'({add_a16, add_b16, add_cin16}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add with nibble sequence and latency
    run16(16'h1234, 16'h0FCD, 1'b0, 1'b0, 0, lat);
    check("t1_lat",    32'(lat), 5);
    check("t1_result", 32'(result16), 32'h2201);
    check("t1_cout",   32'(cout16), 0);
    check("t1_ovf",    32'(ovf16), 0);
    check("t1_busy_done", 32'(busy16), 1);
    for (int i = 0; i < 4; i++) check($sformatf("t1_add_a%0d", i), 32'(nib_seq[i]), 32'(4 - i));
    @(negedge clk);
    check("t1_done_pulse", 32'(done16), 0);
    check("t1_idle_busy",  32'(busy16), 0);
    repeat (3) @(negedge clk);
    check("t1_hold_result", 32'(result16), 32'h2201);

    // Full carry ripple
    run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, lat);
    check("t2_lat",    32'(lat), 5);
    check("t2_result", 32'(result16), 32'h0000);
    check("t2_cout",   32'(cout16), 1);
    check("t2_ovf",    32'(ovf16), 0);
    @(negedge clk);

    // Signed overflow
    run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, lat);
    check("t3_result", 32'(result16), 32'h8000);
    check("t3_cout",   32'(cout16), 0);
    check("t3_ovf",    32'(ovf16), 1);
    @(negedge clk);

    // Subtract with borrow
    run16(16'h0005, 16'h0007, 1'b1, 1'b0, 0, lat);
    check("t4_result", 32'(result16), 32'hFFFE);
    check("t4_cout",   32'(cout16), 0);
    check("t4_ovf",    32'(ovf16), 0);
    @(negedge clk);

    // Subtract with external borrow-in: carry = 1^1 = 0 -> a + ~b
    run16(16'h1000, 16'h0001, 1'b1, 1'b1, 0, lat);
    check("t5_result", 32'(result16), 32'h0FFE);
    check("t5_cout",   32'(cout16), 1);
    @(negedge clk);

    // Add with carry-in
    run16(16'h0010, 16'h0001, 1'b0, 1'b1, 0, lat);
    check("t6_result", 32'(result16), 32'h0012);
    @(negedge clk);

    // Start during RUN cycle 2 ignored; restart right after done accepted
    run16(16'h1111, 16'h2222, 1'b0, 1'b0, 2, lat);
    check("t7_lat",    32'(lat), 5);
    check("t7_result", 32'(result16), 32'h3333);
    check("t7_busy_done", 32'(busy16), 1);
    @(negedge clk);
    run16(16'h4000, 16'h4000, 1'b0, 1'b0, 0, lat);
    check("t7b_lat",    32'(lat), 5);
    check("t7b_result", 32'(result16), 32'h8000);
    check("t7b_ovf",    32'(ovf16), 1);
    @(negedge clk);

    // Asynchronous reset in RUN cycle 3 (idx=2)
    a16 = 16'h1234; b16 = 16'h0FCD; sub = 1'b0; cin = 1'b0; start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t8_add_a_idx2", 32'(add_a16), 2);
    #2 rst_n = 1'b0;
    #1;
    check("t8_busy",   32'(busy16),   0);
    check("t8_done",   32'(done16),   0);
    check("t8_result", 32'(result16), 0);
    check("t8_cout_ovf", 32'({cout16, ovf16}), 0);
    check("t8_add_if", 32'({add_a16, add_b16, add_cin16}), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t8_no_done", 32'({busy16, done16}), 0);
    end
    rst_n = 1'b1;
    run16(16'hABCD, 16'h1111, 1'b0, 1'b0, 0, lat);
    check("t8_lat",    32'(lat), 5);
    check("t8_result", 32'(result16), 32'hBCDE);
    check("t8_cout",   32'(cout16), 0);
    @(negedge clk);

    // 8-bit instance
    run8(8'h80, 8'h80, 1'b0, 1'b0, lat);
    check("t9_lat",    32'(lat), 3);
    check("t9_result", 32'(result8), 0);
    check("t9_cout",   32'(cout8), 1);
    check("t9_ovf",    32'(ovf8), 1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one external 4-bit ripple-carry adder slice, one nibble per clock, LSB nibble first.
- Latches the operands on a start/done handshake, registers the inter-nibble carry, assembles the result, and reports carry-out and signed overflow.
- Sits between a requesting datapath/control unit and a single shared 4-bit adder instance.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 8. NIB = WIDTH/4 nibble steps.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- sub  in  1  0 = a+b, 1 = a-b (b inverted, carry-in toggled); latched with start.
- cin  in  1  external carry/borrow-in; latched with start.
- a  in  WIDTH  operand A; latched with start.
- b  in  WIDTH  operand B; latched with start.
- add_a  out  4  to adder slice: current nibble of latched A.
- add_b  out  4  to adder slice: current nibble of effective B (b or ~b).
- add_cin  out  1  to adder slice: carry register.
- add_s  in  4  sum nibble from adder slice (combinational, same cycle).
- add_cout  in  1  carry-out from adder slice (combinational, same cycle).
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle pulse when the result is valid.
- result  out  WIDTH  assembled sum/difference.
- cout  out  1  final carry-out (for sub: 1 = no borrow).
- ovf  out  1  signed two's-complement overflow.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, idx=0, carry=0, operand regs=0. Outputs: busy=0, done=0, result=0, cout=0, ovf=0. add_a/add_b/add_cin are 0.
- State IDLE:
  - add_a/add_b/add_cin driven 0.
  - start=1 -> latch A=a, Beff = sub ? ~b : b, carry = cin ^ sub, idx=0; go to RUN.
  - result/cout/ovf keep their previous values until the next accepted start, then clear to 0 on entry to RUN.
- State RUN:
  - add_a = A[4*idx+:4], add_b = Beff[4*idx+:4], add_cin = carry.
  - On each edge: result[4*idx+:4] <= add_s, carry <= add_cout, idx <= idx+1.
  - When idx == NIB-1: cout <= add_cout; ovf <= (A[W-1]==Beff[W-1]) && (add_s[3] != A[W-1]); go to DONE.
- State DONE: done=1 for exactly one cycle; result/cout/ovf valid; go to IDLE.
- Latency: start sampled at edge E0 -> RUN for NIB cycles -> done high in cycle NIB+1 after E0 (cycle 5 for WIDTH=16). The next start is accepted in the cycle after done deasserts. Throughput is one operation per NIB+2 cycles.
- start while busy (RUN/DONE): ignored, no queuing; operand/sub/cin changes have no effect.
- busy = (state != IDLE), including the DONE cycle.
- idx width = clog2(NIB); no wrap beyond NIB-1.
- Reset asserted mid-RUN: operation aborted immediately, all outputs go to reset values, no done pulse. After release the block is in IDLE.
- add_s/add_cout are trusted combinational; the controller inserts no extra pipeline stage.

Test Plan:
- WIDTH=16, a=0x1234, b=0x0FCD, sub=0, cin=0 -> done in cycle 5, result=0x2201, cout=0, ovf=0. add_a sequence over the RUN cycles is 4,3,2,1.
- a=0xFFFF, b=0x0001, sub=0, cin=0 -> result=0x0000, cout=1, ovf=0. Carry ripples through all 4 nibble steps.
- a=0x7FFF, b=0x0001, sub=0 -> result=0x8000, cout=0, ovf=1. Also a=0x0005, b=0x0007, sub=1, cin=0 -> result=0xFFFE, cout=0 (borrow), ovf=0.
- Start pulsed again in RUN cycle 2 with different operands -> ignored; first result intact. busy stays high through DONE; a new start in the cycle after done is accepted.
- rst_n dropped asynchronously mid-RUN (idx=2) -> busy/done/result/cout/ovf = 0 immediately, no done pulse. A fresh start after release yields the correct result.
- WIDTH=8 instance, a=0x80, b=0x80, sub=0 -> done in cycle 3, result=0x00, cout=1, ovf=1.
